// File: rtl/mm_pkg.sv
// Shared types and phase-length constants for the matrix-multiply scheduler.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    COMPUTE,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  localparam int DEF_N1 = 4;
  localparam int DEF_N2 = 4;
  localparam int DEF_M  = 8;

  localparam int COMPUTE_LEN = DEF_M * DEF_M / DEF_N1;
  localparam int DRAIN_LEN   = DEF_N1 + DEF_N2;
  localparam int WRITE_LEN   = DEF_N1 * DEF_N2;

  function automatic int computeLen(input int m, input int n1);
    return m * m / n1;
  endfunction

  function automatic int drainLen(input int n1, input int n2);
    return n1 + n2;
  endfunction

  function automatic int writeLen(input int n1, input int n2);
    return n1 * n2;
  endfunction

  // Counter width that can hold 0..count-1, never narrower than one bit
  function automatic int widthFor(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times the COMPUTE and DRAIN phases.
// o_terminal is high while the count sits at zero; the count never wraps.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_en,
  output logic         o_terminal
);

  logic [W-1:0] r_count;

  // Clear wins over load, load wins over counting down; stop at zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_terminal = (r_count == '0);

endmodule

// File: rtl/mm_scheduler.sv
// Job sequencer for a systolic matrix multiplier:
// IDLE -> LOAD -> CLEAR -> COMPUTE -> DRAIN -> WRITE -> DONE -> IDLE.
// Optional feature: define MM_SCHED_PERF_CNT_EN to add the 32-bit cycle_cnt
// output counting the busy cycles of the most recent job.
module mm_scheduler
  import mm_pkg::*;
#(
  parameter int N1 = DEF_N1,
  parameter int N2 = DEF_N2,
  parameter int M  = DEF_M
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          load_req,
  input  logic                          load_done,
  output logic                          cntr_clr,
  output logic                          enable_row_count,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [widthFor(N1*N2)-1:0]    res_idx,
  output logic                          busy,
  output logic                          done
`ifdef MM_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]                   cycle_cnt
`endif
);

  localparam int CLEN  = computeLen(M, N1);
  localparam int DLEN  = drainLen(N1, N2);
  localparam int WLEN  = writeLen(N1, N2);
  localparam int TMR_W = widthFor(maxOf(CLEN, DLEN));
  localparam int IDX_W = widthFor(WLEN);

  state_t             r_state;
  state_t             w_nextState;
  logic               r_loadReq;
  logic               r_cntrClr;
  logic               r_enRowCount;
  logic               r_resValid;
  logic               r_busy;
  logic               r_done;
  logic [IDX_W-1:0]   r_resIdx;

  logic               w_handshake;
  logic               w_lastWord;
  logic               w_tmrLoad;
  logic [TMR_W-1:0]   w_tmrLoadVal;
  logic               w_tmrEn;
  logic               w_tmrTerminal;

  assign w_handshake = r_resValid & res_ready;
  assign w_lastWord  = (r_resIdx == IDX_W'(WLEN - 1));

  // Next-state decision; abort overrides every other request
  always_comb begin
    w_nextState = r_state;
    if (abort) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start)                     w_nextState = LOAD;
        LOAD:    if (load_done)                 w_nextState = CLEAR;
        CLEAR:                                  w_nextState = COMPUTE;
        COMPUTE: if (w_tmrTerminal)             w_nextState = DRAIN;
        DRAIN:   if (w_tmrTerminal)             w_nextState = WRITE;
        WRITE:   if (w_handshake && w_lastWord) w_nextState = DONE;
        DONE:                                   w_nextState = IDLE;
        default:                                w_nextState = IDLE;
      endcase
    end
  end

  // The timer is loaded with length-1 on phase entry so it reads zero in the last cycle
  always_comb begin
    w_tmrLoad    = ((w_nextState == COMPUTE) && (r_state != COMPUTE)) ||
                   ((w_nextState == DRAIN)   && (r_state != DRAIN));
    w_tmrLoadVal = (w_nextState == DRAIN) ? TMR_W'(DLEN - 1) : TMR_W'(CLEN - 1);
    w_tmrEn      = (r_state == COMPUTE) || (r_state == DRAIN);
  end

  phase_timer #(
    .W (TMR_W)
  ) u_phaseTimer (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (abort),
    .i_load     (w_tmrLoad),
    .i_loadVal  (w_tmrLoadVal),
    .i_en       (w_tmrEn),
    .o_terminal (w_tmrTerminal)
  );

  // State register with outputs decoded from the upcoming state so they are registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_loadReq    <= 1'b0;
      r_cntrClr    <= 1'b0;
      r_enRowCount <= 1'b0;
      r_resValid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_resIdx     <= '0;
    end else begin
      r_state      <= w_nextState;
      r_loadReq    <= (w_nextState == LOAD);
      r_cntrClr    <= (w_nextState == CLEAR);
      r_enRowCount <= (w_nextState == COMPUTE);
      r_resValid   <= (w_nextState == WRITE);
      r_busy       <= (w_nextState != IDLE);
      r_done       <= (w_nextState == DONE);
      if (w_nextState != WRITE) begin
        r_resIdx <= '0;
      end else if (w_handshake) begin
        r_resIdx <= r_resIdx + 1'b1;
      end
    end
  end

  assign load_req         = r_loadReq;
  assign cntr_clr         = r_cntrClr;
  assign enable_row_count = r_enRowCount;
  assign res_valid        = r_resValid;
  assign res_idx          = r_resIdx;
  assign busy             = r_busy;
  assign done             = r_done;

`ifdef MM_SCHED_PERF_CNT_EN
  logic [31:0] r_cycleCnt;

  // Busy-cycle counter: restarts on an accepted start, holds while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycleCnt <= '0;
    end else if ((r_state == IDLE) && (w_nextState == LOAD)) begin
      r_cycleCnt <= '0;
    end else if (r_busy) begin
      r_cycleCnt <= r_cycleCnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycleCnt;
`else
  // Performance counter not built in this configuration.
`endif

endmodule

// File: tb/tb_mm_scheduler.sv
// Self-checking bench for mm_scheduler (M=8, N1=4, N2=4).
// Expected output pulse/level windows are derived from the job timeline and
// queued at stimulus time; a negedge monitor measures every output run and
// every result handshake and pops the matching expectation.
module tb_mm_scheduler;

  localparam int N1 = 4;
  localparam int N2 = 4;
  localparam int M  = 8;
  localparam int CL = (M * M) / N1;
  localparam int DL = N1 + N2;
  localparam int WL = N1 * N2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       load_req;
  logic       load_done;
  logic       cntr_clr;
  logic       enable_row_count;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_idx;
  logic       busy;
  logic       done;
`ifdef MM_SCHED_PERF_CNT_EN
  logic [31:0] cycle_cnt;
`endif

  mm_scheduler #(.N1(N1), .N2(N2), .M(M)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .abort            (abort),
    .load_req         (load_req),
    .load_done        (load_done),
    .cntr_clr         (cntr_clr),
    .enable_row_count (enable_row_count),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_idx          (res_idx),
    .busy             (busy),
    .done             (done)
`ifdef MM_SCHED_PERF_CNT_EN
    ,
    .cycle_cnt        (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int sig;
    int s;
    int e;
  } runT;

  runT   expRuns[$];
  int    expIdx[$];
  string sigName[6] = '{"load_req", "cntr_clr", "enable_row_count", "res_valid", "busy", "done"};

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic pushRun(input int sig, input int s, input int e);
    runT r;
    r.sig = sig;
    r.s   = s;
    r.e   = e;
    expRuns.push_back(r);
  endtask

  // Match a measured high-run of one output against the oldest expectation for it
  task automatic checkRun(input int sig, input int s, input int e);
    int found;
    found = -1;
    for (int i = 0; i < expRuns.size(); i++) begin
      if (found < 0 && expRuns[i].sig == sig) found = i;
    end
    checks++;
    if (found < 0) begin
      failures++;
      $display("[TB] FAIL run_%s: unexpected high from cycle %0d to %0d, expected none",
               sigName[sig], s, e);
    end else begin
      if (s != expRuns[found].s || e != expRuns[found].e) begin
        failures++;
        $display("[TB] FAIL run_%s: got cycles %0d..%0d expected %0d..%0d",
                 sigName[sig], s, e, expRuns[found].s, expRuns[found].e);
      end
      expRuns.delete(found);
    end
  endtask

  // Monitor: detect output run edges and result handshakes away from the clock edge
  logic [5:0] curSig;
  logic [5:0] prevSig = '0;
  int         runStart[6];

  always @(negedge clk) begin
    curSig = {done, busy, res_valid, enable_row_count, cntr_clr, load_req};
    if (rst !== 1'b1) begin
      prevSig = '0;
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (curSig[k] && !prevSig[k]) runStart[k] = cyc;
        if (!curSig[k] && prevSig[k]) checkRun(k, runStart[k], cyc - 1);
      end
      if (res_valid && res_ready) begin
        if (expIdx.size() == 0) begin
          checkOutput("res_idx_unexpected_handshake", int'(res_idx), -1);
        end else begin
          checkOutput("res_idx", int'(res_idx), expIdx.pop_front());
        end
      end
      prevSig = curSig;
    end
  end

  task automatic waitNext();
    @(posedge clk);
    #1;
  endtask

  // mode 0: full job, 1: abort in COMPUTE at offset off, 2: abort together with load_done,
  // 3: asynchronous reset in the middle of DRAIN.
  // rdyMode 0: ready always high, 1: random, 2: alternating 1/0.
  task automatic applyStimulus(input int mode, input int ld, input int rdyMode, input int off);
    int s, d, w0, doneC, endC, hs, c;
    bit r;
    bit rdy[$];
    s  = cyc;
    d  = s + ld;
    w0 = d + 2 + CL + DL;
    hs = 0;
    c  = w0;
    while (hs < WL) begin
      case (rdyMode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ((c - w0) % 2 == 0);
      endcase
      if (c - w0 > 200) r = 1'b1;
      rdy.push_back(r);
      if (r) hs++;
      c++;
    end
    doneC = c;

    pushRun(0, s + 1, d);
    case (mode)
      0: begin
        pushRun(1, d + 1, d + 1);
        pushRun(2, d + 2, d + 1 + CL);
        pushRun(3, w0, doneC - 1);
        pushRun(5, doneC, doneC);
        pushRun(4, s + 1, doneC);
        for (int i = 0; i < WL; i++) expIdx.push_back(i);
        endC = doneC;
      end
      1: begin
        pushRun(1, d + 1, d + 1);
        pushRun(2, d + 2, d + 2 + off);
        pushRun(4, s + 1, d + 2 + off);
        endC = d + 2 + off;
      end
      2: begin
        pushRun(4, s + 1, d);
        endC = d;
      end
      default: begin
        pushRun(1, d + 1, d + 1);
        pushRun(2, d + 2, d + 1 + CL);
        pushRun(4, s + 1, 0);
        endC = d + 2 + CL + 3;
      end
    endcase

    for (c = s; c <= endC; c++) begin
      start     = (c == s) ? 1'b1 : 1'($urandom_range(0, 1));
      load_done = (c == d) ? 1'b1 : ((c > d) ? 1'($urandom_range(0, 1)) : 1'b0);
      abort     = ((mode == 1) || (mode == 2)) && (c == endC);
      res_ready = (c >= w0 && (c - w0) < rdy.size()) ? rdy[c - w0] : 1'($urandom_range(0, 1));
      if (mode == 3 && c == endC) begin
        checkOutput("drain_busy_before_reset", int'(busy), 1);
        #2;
        rst = 1'b0;
        expRuns.delete();
        expIdx.delete();
        #1;
        checkOutput("async_reset_outputs",
                    int'({load_req, cntr_clr, enable_row_count, res_valid, busy, done, res_idx}), 0);
      end
      waitNext();
    end
    start     = 1'b0;
    abort     = 1'b0;
    load_done = 1'b0;
    if (mode == 3) rst = 1'b1;
`ifdef MM_SCHED_PERF_CNT_EN
    if (mode == 0) checkOutput("cycle_cnt", int'(cycle_cnt), doneC - s);
`endif
    repeat ($urandom_range(1, 3)) begin
      res_ready = 1'($urandom_range(0, 1));
      load_done = 1'($urandom_range(0, 1));
      waitNext();
    end
    load_done = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    load_done = 1'b0;
    res_ready = 1'b0;
    waitNext();
    waitNext();
    checkOutput("reset_outputs",
                int'({load_req, cntr_clr, enable_row_count, res_valid, busy, done, res_idx}), 0);
    rst = 1'b1;
    waitNext();

    $display("[TB] nominal job, ready held high");
    applyStimulus(0, 3, 0, 0);
    $display("[TB] ready alternating during WRITE");
    applyStimulus(0, 1, 2, 0);
    $display("[TB] abort in COMPUTE, then nominal replay");
    applyStimulus(1, 3, 0, 5);
    applyStimulus(0, 3, 0, 0);
    $display("[TB] abort coincident with load_done");
    applyStimulus(2, 2, 0, 0);

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    waitNext();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("abort_over_start_busy", int'(busy), 0);
    checkOutput("abort_over_start_load_req", int'(load_req), 0);
    waitNext();

    $display("[TB] reset in the middle of DRAIN");
    applyStimulus(3, 2, 0, 0);
    waitNext();

    $display("[TB] randomized jobs");
    for (int j = 0; j < 6; j++) begin
      int mode;
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      applyStimulus(mode, $urandom_range(1, 5), $urandom_range(0, 2), $urandom_range(0, CL - 1));
    end

    repeat (4) waitNext();
    checkOutput("pending_expectations", expRuns.size() + expIdx.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mm_scheduler.md
MM_SCHEDULER -- requirements
Module: mm_scheduler

Interface
REQ-001 SHALL have parameter N1, default 4, meaning systolic rows (A slices per pass).
REQ-002 SHALL have parameter N2, default 4, meaning systolic columns.
REQ-003 SHALL have parameter M, default 8, meaning square matrix dimension; M divisible by N1 and N2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, job request, sampled in IDLE only.
REQ-007 SHALL have port abort, input, 1, cancels the current job from any state.
REQ-008 SHALL have port load_req, output, 1, requests A/B operand BRAM fill.
REQ-009 SHALL have port load_done, input, 1, operand fill complete.
REQ-010 SHALL have port cntr_clr, output, 1, one-cycle clear to the A/B address counters.
REQ-011 SHALL have port enable_row_count, output, 1, advances the A address counter.
REQ-012 SHALL have port res_valid, output, 1, result word available.
REQ-013 SHALL have port res_ready, input, 1, result sink accepts a word.
REQ-014 SHALL have port res_idx, output, $clog2(N1*N2), index of the current result word.
REQ-015 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-016 SHALL have port done, output, 1, one-cycle job-complete pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, CLEAR, COMPUTE, DRAIN, WRITE, DONE.
REQ-018 IDLE->LOAD SHALL occur on the edge where start=1; start in other states SHALL be ignored.
REQ-019 load_req SHALL be 1 in every LOAD cycle; LOAD->CLEAR SHALL occur on the edge where load_done=1.
REQ-020 CLEAR SHALL last exactly 1 cycle with cntr_clr=1; cntr_clr SHALL be 0 elsewhere.
REQ-021 COMPUTE SHALL last exactly M*M/N1 cycles with enable_row_count=1; enable_row_count SHALL be 0 elsewhere.
REQ-022 DRAIN SHALL last exactly N1+N2 cycles (array flush).
REQ-023 WRITE SHALL hold res_valid=1 until N1*N2 handshakes (res_valid&res_ready) complete; res_idx SHALL start at 0 and increment per handshake.
REQ-024 After the handshake with res_idx=N1*N2-1, the FSM SHALL enter DONE (done=1 for one cycle), then IDLE.
REQ-025 res_valid SHALL NOT drop without a handshake; res_ready low SHALL stall res_idx.
REQ-026 abort=1 SHALL force IDLE on the next edge from any state, clear all counters, and suppress done; abort SHALL take priority over start and load_done in the same cycle.
REQ-027 Phase counters SHALL be sized $clog2 of their terminal count and SHALL NOT wrap past their terminal count.

Reset
REQ-028 rst low SHALL asynchronously force IDLE, all counters 0, and all outputs 0 (res_idx=0, busy=0).
REQ-029 Reset asserted mid-job SHALL discard the job; no done pulse SHALL be emitted.

Configuration
REQ-030 With MM_SCHED_PERF_CNT_EN defined, the block SHALL add output cycle_cnt (32 bits), cleared on IDLE->LOAD, incremented every busy cycle, and held after DONE until the next start.
REQ-031 Without MM_SCHED_PERF_CNT_EN, the cycle_cnt port and its logic SHALL be absent.

Structure
REQ-032 The FSM state enum and the phase-length constants (COMPUTE_LEN=M*M/N1, DRAIN_LEN=N1+N2, WRITE_LEN=N1*N2) SHALL reside in shared package mm_pkg.
REQ-033 A single sub-module, phase_timer (loadable down-counter with terminal flag), SHALL time COMPUTE and DRAIN.

Verification (M=8, N1=4, N2=4)
REQ-034 start@c0, load_done@c3, res_ready=1 -> LOAD c1-c3, cntr_clr@c4, enable_row_count c5-c20, DRAIN c21-c28, res_valid c29-c44 with res_idx 0..15, done@c45, busy=0@c46.
REQ-035 res_ready toggled 1/0 during WRITE -> res_idx holds while ready=0, exactly 16 handshakes, res_valid never drops early.
REQ-036 abort@c10 (COMPUTE) -> IDLE@c11, enable_row_count=0, no done; a new start then replays REQ-034 timing.
REQ-037 rst low mid-DRAIN -> outputs 0 immediately without a clock edge; start pulsed while busy -> no effect.
REQ-038 MM_SCHED_PERF_CNT_EN defined, REQ-034 stimulus -> cycle_cnt=45 after done.
